// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer write arbiter: screen geometry,
// arbiter state encoding and the pixel write record.
package fb_pkg;

   localparam int FB_SCREEN_W = 640;
   localparam int FB_SCREEN_H = 480;
   localparam int FB_PIXELS   = FB_SCREEN_W * FB_SCREEN_H;
   localparam int FB_ADDR_W   = $clog2(FB_PIXELS);

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_CLEAR      = 2'd1,
      ST_DRAIN_HOLD = 2'd2
   } arb_state_t;

   typedef struct packed {
      logic [FB_ADDR_W-1:0] addr;
      logic                 data;
   } pix_wr_t;

endpackage

// File: rtl/fb_write_arbiter_if.sv
// Bus bundle between the clear sequencer, draw engine, framebuffer write port
// and the arbiter; slave is the arbiter side, master the surrounding logic.
interface fb_write_arbiter_if #(
   parameter int ADDR_WIDTH = fb_pkg::FB_ADDR_W,
   parameter int CNT_WIDTH  = 16
);
   logic                  clr_active;
   logic                  clr_wr_en;
   logic [ADDR_WIDTH-1:0] clr_addr;
   logic                  clr_data;
   logic                  drw_valid;
   logic                  drw_ready;
   logic [ADDR_WIDTH-1:0] drw_addr;
   logic                  drw_data;
   logic                  fb_wr_en;
   logic [ADDR_WIDTH-1:0] fb_addr;
   logic                  fb_data;
   logic                  clr_blocking;
   logic [CNT_WIDTH-1:0]  drop_count;

   modport slave (
      input  clr_active, clr_wr_en, clr_addr, clr_data,
      input  drw_valid, drw_addr, drw_data,
      output drw_ready, fb_wr_en, fb_addr, fb_data, clr_blocking, drop_count
   );

   modport master (
      output clr_active, clr_wr_en, clr_addr, clr_data,
      output drw_valid, drw_addr, drw_data,
      input  drw_ready, fb_wr_en, fb_addr, fb_data, clr_blocking, drop_count
   );
endinterface

// File: rtl/fb_draw_fifo.sv
// Synchronous FIFO buffering draw-engine pixel writes; combinational head read.
module fb_draw_fifo #(
   parameter int WIDTH = 20,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count_q;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_q == (PTR_W+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign dout    = mem[rd_ptr];
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   // Storage carries no reset; only pointers and occupancy define validity.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end
endmodule

// File: rtl/fb_write_arbiter.sv
// Framebuffer write-port arbiter: clear writes always win, draw writes queue
// in a FIFO and are held off until a clear finishes. Optional out-of-range draw
// filtering is enabled by defining FB_ARB_OOB_FILTER_EN.
//
// state         | meaning
// ST_IDLE       | draw FIFO may pop into the write port
// ST_CLEAR      | clear engine owns the port; FIFO accepts, never pops
// ST_DRAIN_HOLD | one-cycle guard after the last clear write
module fb_write_arbiter
   import fb_pkg::*;
#(
   parameter int SCREEN_WIDTH  = 640,
   parameter int SCREEN_HEIGHT = 480,
   parameter int ADDR_WIDTH    = $clog2(SCREEN_WIDTH*SCREEN_HEIGHT),
   parameter int FIFO_DEPTH    = 16,
   parameter int CNT_WIDTH     = 16
) (
   input  logic                clk,
   input  logic                reset,
   fb_write_arbiter_if.slave   bus
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   arb_state_t          state_q, state_d;
   logic                ready_en_q;
   logic                fb_wr_en_q;
   logic [ADDR_WIDTH-1:0] fb_addr_q;
   logic                fb_data_q;
   logic                clr_blocking_q;

   logic                fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic [ADDR_WIDTH:0] fifo_din, fifo_dout;
   logic [CW-1:0]       fifo_count;
   logic                drw_accept;

   // Ready depends only on registered state, never on drw_valid.
   assign bus.drw_ready = ready_en_q & ~fifo_full;
   assign drw_accept    = bus.drw_valid & bus.drw_ready;
   assign fifo_din      = {bus.drw_addr, bus.drw_data};
   assign fifo_pop      = (state_q == ST_IDLE) & ~bus.clr_wr_en & ~bus.clr_active & ~fifo_empty;

`ifdef FB_ARB_OOB_FILTER_EN
   localparam logic [ADDR_WIDTH:0] PIXELS = (ADDR_WIDTH+1)'(SCREEN_WIDTH*SCREEN_HEIGHT);
   logic                 addr_oob;
   logic [CNT_WIDTH-1:0] drop_q;

   assign addr_oob       = ({1'b0, bus.drw_addr} >= PIXELS);
   assign fifo_push      = drw_accept & ~addr_oob;
   assign bus.drop_count = drop_q;

   always_ff @(posedge clk) begin
      if (reset)                                 drop_q <= '0;
      else if (drw_accept && addr_oob && !(&drop_q)) drop_q <= drop_q + 1'b1;
   end
`else
   assign fifo_push      = drw_accept;
   assign bus.drop_count = {CNT_WIDTH{1'b0}};
`endif

   fb_draw_fifo #(
      .WIDTH (ADDR_WIDTH + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (fifo_din),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:       if (bus.clr_active || bus.clr_wr_en) state_d = ST_CLEAR;
         ST_CLEAR:      if (!bus.clr_active && !bus.clr_wr_en) state_d = ST_DRAIN_HOLD;
         ST_DRAIN_HOLD: state_d = bus.clr_active ? ST_CLEAR : ST_IDLE;
         default:       state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         ready_en_q     <= 1'b0;
         fb_wr_en_q     <= 1'b0;
         fb_addr_q      <= '0;
         fb_data_q      <= 1'b0;
         clr_blocking_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         ready_en_q     <= 1'b1;
         clr_blocking_q <= (state_d == ST_CLEAR) || (state_d == ST_DRAIN_HOLD);
         if (bus.clr_wr_en) begin
            fb_wr_en_q <= 1'b1;
            fb_addr_q  <= bus.clr_addr;
            fb_data_q  <= bus.clr_data;
         end else if (fifo_pop) begin
            fb_wr_en_q <= 1'b1;
            fb_addr_q  <= fifo_dout[ADDR_WIDTH:1];
            fb_data_q  <= fifo_dout[0];
         end else begin
            fb_wr_en_q <= 1'b0;
         end
      end
   end

   assign bus.fb_wr_en     = fb_wr_en_q;
   assign bus.fb_addr      = fb_addr_q;
   assign bus.fb_data      = fb_data_q;
   assign bus.clr_blocking = clr_blocking_q;

   // Flag and occupancy views of the FIFO must never disagree.
   a_fifo_flags: assert property (@(posedge clk) disable iff (reset)
      (fifo_empty == (fifo_count == '0)) && (fifo_full == (fifo_count == CW'(FIFO_DEPTH))));
endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter; OOB expectations follow FB_ARB_OOB_FILTER_EN.
module tb_fb_write_arbiter;
   import fb_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   fb_write_arbiter_if #(.ADDR_WIDTH(FB_ADDR_W), .CNT_WIDTH(16)) bus();

   fb_write_arbiter u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_chk = 0;
   int n_bad = 0;
   int cyc   = 0;
   pix_wr_t wr_q[$];
   int      cyc_q[$];
   pix_wr_t exp_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.fb_wr_en === 1'b1) begin
         wr_q.push_back({bus.fb_addr, bus.fb_data});
         cyc_q.push_back(cyc);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic pix_wr_t px(input int a, input bit d);
      return {FB_ADDR_W'(a), d};
   endfunction

   task automatic clr_logs();
      wr_q.delete();
      cyc_q.delete();
      exp_q.delete();
   endtask

   task automatic cmp_log(input string tag);
      chk({tag, "_count"}, wr_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
         chk($sformatf("%s_%0d", tag, i), 32'(wr_q[i]), 32'(exp_q[i]));
   endtask

   task automatic idle_inputs();
      bus.clr_active = 1'b0;
      bus.clr_wr_en  = 1'b0;
      bus.clr_addr   = '0;
      bus.clr_data   = 1'b0;
      bus.drw_valid  = 1'b0;
      bus.drw_addr   = '0;
      bus.drw_data   = 1'b0;
   endtask

   task automatic drw(input int a, input bit d);
      bus.drw_valid = 1'b1;
      bus.drw_addr  = FB_ADDR_W'(a);
      bus.drw_data  = d;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int rdy_cnt;
      idle_inputs();
      reset = 1'b1;
      tick(3);
      chk("rst_fb_wr_en", bus.fb_wr_en, 0);
      chk("rst_fb_addr", bus.fb_addr, 0);
      chk("rst_fb_data", bus.fb_data, 0);
      chk("rst_drw_ready", bus.drw_ready, 0);
      chk("rst_clr_blocking", bus.clr_blocking, 0);
      chk("rst_drop_count", bus.drop_count, 0);
      reset = 1'b0;
      tick();
      chk("rel_drw_ready", bus.drw_ready, 1);
      chk("rel_fb_wr_en", bus.fb_wr_en, 0);
      chk("rel_no_writes", wr_q.size(), 0);

      // idle draw: two back-to-back pushes
      clr_logs();
      drw(100, 1'b1);
      tick();
      chk("idle_wr_en_t1", bus.fb_wr_en, 0);
      drw(101, 1'b1);
      tick();
      chk("idle_wr_en_t2", bus.fb_wr_en, 1);
      chk("idle_addr_t2", bus.fb_addr, 100);
      bus.drw_valid = 1'b0;
      tick();
      chk("idle_wr_en_t3", bus.fb_wr_en, 1);
      chk("idle_addr_t3", bus.fb_addr, 101);
      tick();
      chk("idle_wr_en_t4", bus.fb_wr_en, 0);
      chk("idle_addr_hold", bus.fb_addr, 101);
      exp_q.push_back(px(100, 1'b1));
      exp_q.push_back(px(101, 1'b1));
      cmp_log("idle");
      if (cyc_q.size() == 2) chk("idle_back_to_back", cyc_q[1] - cyc_q[0], 1);

      // clear stream blocks queued draws
      clr_logs();
      for (int i = 0; i < 10; i++) begin
         bus.clr_active = 1'b1;
         bus.clr_wr_en  = 1'b1;
         bus.clr_addr   = FB_ADDR_W'(i);
         bus.clr_data   = i[0];
         if (i < 5) drw(200 + i, 1'b1);
         else       bus.drw_valid = 1'b0;
         tick();
         if (i == 3) chk("clr_blocking_mid", bus.clr_blocking, 1);
      end
      idle_inputs();
      tick(12);
      for (int i = 0; i < 10; i++) exp_q.push_back(px(i, i[0]));
      for (int i = 0; i < 5; i++)  exp_q.push_back(px(200 + i, 1'b1));
      cmp_log("clr");
      if (cyc_q.size() == 15) chk("clr_guard_gap", cyc_q[10] - cyc_q[9], 3);

      // fill the FIFO during a clear, 17th request stalls
      clr_logs();
      bus.clr_active = 1'b1;
      rdy_cnt = 0;
      for (int k = 0; k < 16; k++) begin
         drw(300 + k, k[0]);
         if (bus.drw_ready) rdy_cnt++;
         tick();
      end
      chk("full_accepts", rdy_cnt, 16);
      drw(316, 1'b1);
      chk("full_ready_lo", bus.drw_ready, 0);
      tick(3);
      chk("full_ready_held", bus.drw_ready, 0);
      bus.clr_active = 1'b0;
      tick(2);
      chk("full_ready_guard", bus.drw_ready, 0);
      tick();
      chk("full_ready_after_pop", bus.drw_ready, 1);
      chk("full_first_pop", bus.fb_addr, 300);
      tick();
      bus.drw_valid = 1'b0;
      tick(20);
      for (int k = 0; k < 16; k++) exp_q.push_back(px(300 + k, k[0]));
      exp_q.push_back(px(316, 1'b1));
      cmp_log("full");

      // clear write collides with a non-empty FIFO in IDLE
      clr_logs();
      bus.clr_active = 1'b1;
      drw(400, 1'b0); tick();
      drw(401, 1'b1); tick();
      drw(402, 1'b0); tick();
      idle_inputs();
      tick();
      chk("sim_blocking_hold", bus.clr_blocking, 1);
      tick();
      chk("sim_blocking_idle", bus.clr_blocking, 0);
      chk("sim_count_pre", u_dut.fifo_count, 3);
      bus.clr_wr_en = 1'b1;
      bus.clr_addr  = '0;
      bus.clr_data  = 1'b1;
      tick();
      chk("sim_wr_en", bus.fb_wr_en, 1);
      chk("sim_addr", bus.fb_addr, 0);
      chk("sim_data", bus.fb_data, 1);
      chk("sim_blocking", bus.clr_blocking, 1);
      chk("sim_count_held", u_dut.fifo_count, 3);
      bus.clr_wr_en = 1'b0;
      tick(8);
      exp_q.push_back(px(0, 1'b1));
      exp_q.push_back(px(400, 1'b0));
      exp_q.push_back(px(401, 1'b1));
      exp_q.push_back(px(402, 1'b0));
      cmp_log("sim");

      // out-of-range draw address
      clr_logs();
      drw(307200, 1'b1); tick();
      drw(307199, 1'b1); tick();
      bus.drw_valid = 1'b0;
      tick(4);
`ifdef FB_ARB_OOB_FILTER_EN
      exp_q.push_back(px(307199, 1'b1));
      chk("oob_drop_count", bus.drop_count, 1);
`else
      exp_q.push_back(px(307200, 1'b1));
      exp_q.push_back(px(307199, 1'b1));
      chk("oob_drop_count", bus.drop_count, 0);
`endif
      cmp_log("oob");

      // reset during the drain guard discards queued draws
      clr_logs();
      bus.clr_active = 1'b1;
      drw(500, 1'b1); tick();
      drw(501, 1'b1); tick();
      idle_inputs();
      tick();
      reset = 1'b1;
      tick();
      chk("mid_rst_ready", bus.drw_ready, 0);
      chk("mid_rst_wr_en", bus.fb_wr_en, 0);
      chk("mid_rst_drop", bus.drop_count, 0);
      reset = 1'b0;
      tick(6);
      chk("mid_rst_no_writes", wr_q.size(), 0);
      chk("mid_rst_ready_back", bus.drw_ready, 1);
      chk("mid_rst_blocking", bus.clr_blocking, 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule

// File: doc/fb_write_arbiter.md
Name: fb_write_arbiter

Overview:
Shares the single framebuffer write port between the clear engine (the swap/clear sequencer) and the waveform draw engine.
- Clear traffic always wins.
- Draw writes are buffered in a small FIFO and are held off while a clear is in progress, so the clear never overwrites freshly drawn pixels.
- Sits between the clear sequencer, the draw engine and the framebuffer BRAM write port, in the 100 MHz system clock domain.

Parameters:
SCREEN_WIDTH, 640, pixels per line
SCREEN_HEIGHT, 480, lines per frame
ADDR_WIDTH, $clog2(SCREEN_WIDTH*SCREEN_HEIGHT), framebuffer address width (19 at defaults)
FIFO_DEPTH, 16, draw FIFO entries; power of two, >=2
CNT_WIDTH, 16, width of drop counter

Ports:
clk  in  1  system clock, single clock domain
reset  in  1  synchronous, active-high reset
clr_active  in  1  clear sequence in progress (level)
clr_wr_en  in  1  clear engine write strobe
clr_addr  in  ADDR_WIDTH  clear write address
clr_data  in  1  clear write pixel
drw_valid  in  1  draw request valid
drw_ready  out  1  draw request accepted this cycle when valid&ready
drw_addr  in  ADDR_WIDTH  draw pixel address
drw_data  in  1  draw pixel value
fb_wr_en  out  1  framebuffer write enable
fb_addr  out  ADDR_WIDTH  framebuffer write address
fb_data  out  1  framebuffer write pixel
clr_blocking  out  1  high while the FSM is in CLEAR or DRAIN_HOLD
drop_count  out  CNT_WIDTH  out-of-range draw requests discarded, saturating

Behaviour:
- Reset (sampled on clk when reset=1):
  - fb_wr_en=0, fb_addr=0, fb_data=0, drw_ready=0, clr_blocking=0, drop_count=0.
  - FIFO emptied; FSM=IDLE.
  - drw_ready goes high the first cycle after reset deasserts.
  - Reset mid-clear or mid-drain discards all FIFO contents; no partial write is issued.
- FSM states:
  - IDLE: draw traffic allowed.
    - clr_active=1 or clr_wr_en=1 -> CLEAR (same-cycle clear grant).
  - CLEAR: clear port owns the write port; FIFO accepts but never pops.
    - clr_active=0 and clr_wr_en=0 -> DRAIN_HOLD.
  - DRAIN_HOLD: one-cycle guard so the last clear write lands before any draw write.
    - Always -> IDLE, unless clr_active=1, which -> CLEAR.
- Grant and output timing:
  - Output registers: fb_* are registered, so latency is 1 cycle from grant to fb_wr_en.
  - Clear grant: any cycle with clr_wr_en=1, regardless of state, gives fb_wr_en<=1, fb_addr<=clr_addr, fb_data<=clr_data.
  - Draw grant: only in IDLE, with clr_wr_en=0, clr_active=0 and FIFO non-empty. Pops the head and gives fb_wr_en<=1 with the head's addr/data.
  - At most one pop per cycle; otherwise fb_wr_en<=0, and fb_addr/fb_data hold their previous values.
- FIFO handshake:
  - drw_ready = !full, derived from registered state only; no combinational path from drw_valid.
  - Push when drw_valid&drw_ready.
  - Simultaneous push+pop is legal at any occupancy except full; the count is unchanged.
  - When full, drw_ready=0 and the draw engine stalls.
  - Pointers are ADDR wrap-around mod FIFO_DEPTH.
  - Count width is $clog2(FIFO_DEPTH)+1.
- Ordering: draw writes leave in acceptance order; clear writes pass through in arrival order.
- Simultaneous clr_wr_en and FIFO non-empty in IDLE: clear wins, the FSM enters CLEAR, and the FIFO holds.
- clr_blocking is a registered decode of the state (CLEAR or DRAIN_HOLD).

Optional Feature:
FB_ARB_OOB_FILTER_EN
- Defined:
  - On push, any drw_addr >= SCREEN_WIDTH*SCREEN_HEIGHT is accepted (handshake completes) but not stored.
  - drop_count increments by 1, saturating at all-ones.
- Undefined:
  - All accepted requests are stored and written unmodified.
  - drop_count is tied to 0.

Decomposition:
- Shared package fb_pkg:
  - FB_PIXELS = SCREEN_WIDTH*SCREEN_HEIGHT
  - FB_ADDR_W
  - FSM state encoding IDLE/CLEAR/DRAIN_HOLD (2-bit)
  - pixel write record (addr, data)
- One sub-module: fb_draw_fifo, a synchronous FIFO with push/pop/full/empty and a count output, instantiated once.
- Arbiter FSM and output registers stay in the top.

Test Plan:
- Reset release: hold reset 3 cycles -> all outputs 0; drw_ready=1 on the first cycle after release; no fb_wr_en.
- Idle draw: push addr 100/data 1, then addr 101/data 1 -> fb_wr_en pulses on cycles T+2 and T+3, each 1 cycle after its pop, with fb_addr 100 then 101 in order.
- Clear blocks draw: raise clr_active, stream clr_addr 0..9 while pushing 5 draw writes -> fb shows only addrs 0..9.
  - After clr_active falls, one idle guard cycle, then the 5 draw writes in order.
- FIFO full: during CLEAR push 17 requests with FIFO_DEPTH=16 -> drw_ready=0 after the 16th acceptance; the 17th is held until the first pop after DRAIN_HOLD.
- Simultaneous: FIFO holds 3 entries in IDLE while clr_wr_en=1 addr 0 arrives -> next cycle fb_addr=0 (clear); clr_blocking=1; FIFO count stays 3.
- OOB filter (macro defined): push addr 307200 and then 307199 -> only 307199 written; drop_count=1.
  - With the macro undefined, both are written and drop_count=0.
